sobel_mag_scheduler: RTL and testbench
======================================

Name: sobel_mag_scheduler

Overview:
- Shares one pipelined gradient-magnitude unit (|gx|+|gy|, saturated to 8 bits) between NUM_LANES Sobel convolution lanes.
- Round-robin arbitration with valid/ready handshakes on every requester and on the single output, so four parallel convolvers feed one magnitude datapath.
- Tags each result with its source lane.
- Keeps a running count of pixels whose magnitude reaches a programmable edge threshold.

Parameters:
- NUM_LANES, 4: number of requesting gradient lanes (2..8).
- GW, 11: width of signed two's-complement gx/gy inputs.
- CNT_W, 16: width of edge_count.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- lane_valid  in  NUM_LANES  lane i presents a gradient pair
- lane_gx  in  NUM_LANES*GW  packed signed gx; lane i at [i*GW +: GW]
- lane_gy  in  NUM_LANES*GW  packed signed gy, same packing
- lane_ready  out  NUM_LANES  one-hot grant; a transfer happens when lane_valid[i] & lane_ready[i]
- threshold  in  8  edge threshold, sampled in stage 2
- clear_count  in  1  synchronous clear of edge_count
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_pixel  out  8  saturated magnitude
- out_lane  out  $clog2(NUM_LANES)  source lane of out_pixel
- out_edge  out  1  out_pixel >= threshold
- edge_count  out  CNT_W  count of accepted results with out_edge=1, saturating

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_pixel=0, out_lane=0, out_edge=0, edge_count=0, rr_ptr=0, stage-1 valid=0. lane_ready is combinational and is 0 while rst=1. Reset mid-operation drops all in-flight data without producing an output.
- Pipeline: two register stages.
  - S1 registers |gx|, |gy| and the lane index.
  - S2 registers out_pixel, out_lane and out_edge.
  - Latency from input handshake to out_valid=1 is 2 cycles when there is no stall.
- Stall rules:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - When out_valid & !out_ready, S2 holds and S1 holds if it is occupied.
  - An input is accepted only when s1_adv=1.
  - Throughput is 1 per cycle with out_ready held at 1.
- Arbitration:
  - Combinational round-robin among lanes with lane_valid=1, starting the search at rr_ptr.
  - lane_ready has at most one bit set, and only when s1_adv=1.
  - On an accepted transfer, rr_ptr <= granted+1, wrapping to 0 after NUM_LANES-1. rr_ptr is unchanged when no transfer happens.
  - Grant does not depend on lane_gx/lane_gy.
- Arithmetic:
  - abs is two's-complement negate when the MSB is set; the result is an unsigned GW-bit value, so -1024 gives 1024.
  - Sum is computed at GW+1 bits with no overflow loss.
  - out_pixel = 255 if sum > 255, else sum[7:0].
  - out_edge = (saturated value >= threshold), so threshold=0 flags every pixel.
- edge_count:
  - Increments when out_valid & out_ready & out_edge.
  - Holds at 2^CNT_W-1 instead of wrapping.
  - If clear_count and an increment occur in the same cycle, clear wins and the count becomes 0.
- Handshake stability: out_pixel, out_lane and out_edge stay stable while out_valid & !out_ready.
  - Lanes may drop lane_valid without a grant; no ordering guarantee across lanes.
  - Per-lane order is preserved.

Decomposition:
- Package sobel_pkg holds:
  - localparams PIX_MAX=255 and GRAD_W=11.
  - typedef pix_t (logic [7:0]).
  - typedef grad_t (logic signed [GRAD_W-1:0]).
  - function sat_mag(grad_t gx, grad_t gy) returning pix_t, shared with the standalone magnitude stage.
- Sub-module rr_arbiter (NUM_LANES):
  - Inputs: req vector, enable (s1_adv), advance strobe.
  - Outputs: one-hot grant and index.
  - Owns rr_ptr.
- Top level: pipeline registers, stall logic, edge counter.

Test Plan:
- Single lane 0, gx=-3 (11'h7FD), gy=4, out_ready=1 -> out_valid 2 cycles later; out_pixel=7, out_lane=0; out_edge=0 with threshold=100.
- Saturation and extremes: gx=-1024, gy=0 -> out_pixel=255; gx=200, gy=100 -> 255; gx=127, gy=128 -> 255; gx=127, gy=127 -> 254.
- All four lanes valid continuously, out_ready=1 -> grants 0,1,2,3,0,...; one result per cycle; out_lane sequence matches the grants.
- Backpressure: stream 5 pixels from lane 2, drop out_ready for 3 cycles mid-stream -> outputs held stable, lane_ready=0 while S1 and S2 are full, no loss or duplication, order preserved.
- Counter: threshold=50, accept magnitudes 49, 50, 255 -> edge_count=2; clear_count asserted in the same cycle as an edge accept -> edge_count=0; preload near max (CNT_W=4) -> holds at 15.
- Reset mid-stream with S1 and S2 full -> next cycle out_valid=0, edge_count=0, rr_ptr=0 (lane 0 granted first when all valid).

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel gradient-magnitude datapath.
package sobel_pkg;

    localparam int unsigned PIX_MAX = 255;
    localparam int unsigned GRAD_W  = 11;

    typedef logic [7:0]               pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;

    // |gx|+|gy| saturated to 8 bits; abs is unsigned so the most negative input keeps its magnitude
    function automatic pix_t sat_mag(grad_t gx, grad_t gy);
        logic [GRAD_W-1:0] ax;
        logic [GRAD_W-1:0] ay;
        logic [GRAD_W:0]   s;
        ax = gx[GRAD_W-1] ? (~gx + GRAD_W'(1)) : gx;
        ay = gy[GRAD_W-1] ? (~gy + GRAD_W'(1)) : gy;
        s  = {1'b0, ax} + {1'b0, ay};
        return (s > (GRAD_W+1)'(PIX_MAX)) ? pix_t'(PIX_MAX) : s[7:0];
    endfunction

endpackage

// File: rtl/sobel_mag_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at rr_ptr, pointer moves past the winner on a transfer.
module rr_arbiter #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] req_i,
    input  logic                 en_i,
    input  logic                 adv_i,
    output logic [NUM_LANES-1:0] gnt_c,
    output logic [IDX_W-1:0]     idx_c
);
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NUM_LANES);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_c = cand;
            end
        end
        if (found && en_i) gnt_c[idx_c] = 1'b1;

        ptr_d = ptr_q;
        if (adv_i) ptr_d = (32'(idx_c) == NUM_LANES - 1) ? '0 : idx_c + IDX_W'(1);
    end
endmodule

// File: rtl/sobel_mag_scheduler.sv
// Shares one two-stage |gx|+|gy| magnitude pipeline between NUM_LANES requesters.
module sobel_mag_scheduler
    import sobel_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned GW        = 11,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_LANES-1:0]    lane_valid,
    input  logic [NUM_LANES*GW-1:0] lane_gx,
    input  logic [NUM_LANES*GW-1:0] lane_gy,
    output logic [NUM_LANES-1:0]    lane_ready,
    input  logic [7:0]              threshold,
    input  logic                    clear_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_pixel,
    output logic [IDX_W-1:0]        out_lane,
    output logic                    out_edge,
    output logic [CNT_W-1:0]        edge_count
);
    logic             s1_valid_q, s1_valid_d;
    logic [GW-1:0]    s1_ax_q, s1_ax_d, s1_ay_q, s1_ay_d;
    logic [IDX_W-1:0] s1_lane_q, s1_lane_d;
    logic             out_valid_q, out_valid_d;
    pix_t             out_pixel_q, out_pixel_d;
    logic [IDX_W-1:0] out_lane_q, out_lane_d;
    logic             out_edge_q, out_edge_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;

    logic             s1_adv, s2_adv, accept;
    logic [IDX_W-1:0] arb_idx;
    logic [GW-1:0]    sel_gx, sel_gy;
    logic [GW:0]      sum;
    pix_t             sat;

    assign s2_adv = !out_valid_q || out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign accept = |(lane_valid & lane_ready);

    // Grant is withheld during reset so nothing is accepted into a pipeline being flushed
    rr_arbiter #(.NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (lane_valid),
        .en_i  (s1_adv && !rst),
        .adv_i (accept),
        .gnt_c (lane_ready),
        .idx_c (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_ax_q      <= '0;
            s1_ay_q      <= '0;
            s1_lane_q    <= '0;
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            out_lane_q   <= '0;
            out_edge_q   <= 1'b0;
            edge_count_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_ax_q      <= s1_ax_d;
            s1_ay_q      <= s1_ay_d;
            s1_lane_q    <= s1_lane_d;
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
            out_lane_q   <= out_lane_d;
            out_edge_q   <= out_edge_d;
            edge_count_q <= edge_count_d;
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_ax_d      = s1_ax_q;
        s1_ay_d      = s1_ay_q;
        s1_lane_d    = s1_lane_q;
        out_valid_d  = out_valid_q;
        out_pixel_d  = out_pixel_q;
        out_lane_d   = out_lane_q;
        out_edge_d   = out_edge_q;
        edge_count_d = edge_count_q;

        sel_gx = lane_gx[32'(arb_idx)*GW +: GW];
        sel_gy = lane_gy[32'(arb_idx)*GW +: GW];
        sum    = {1'b0, s1_ax_q} + {1'b0, s1_ay_q};
        sat    = (sum > (GW+1)'(PIX_MAX)) ? pix_t'(PIX_MAX) : sum[7:0];

        // Stage 1: absolute values of the granted lane
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_ax_d   = sel_gx[GW-1] ? (~sel_gx + GW'(1)) : sel_gx;
                s1_ay_d   = sel_gy[GW-1] ? (~sel_gy + GW'(1)) : sel_gy;
                s1_lane_d = arb_idx;
            end
        end

        // Stage 2: saturated sum and threshold compare
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_pixel_d = sat;
                out_lane_d  = s1_lane_q;
                out_edge_d  = (sat >= threshold);
            end
        end

        if (clear_count)
            edge_count_d = '0;
        else if (out_valid_q && out_ready && out_edge_q && (edge_count_q != '1))
            edge_count_d = edge_count_q + CNT_W'(1);
    end

    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;
    assign out_lane   = out_lane_q;
    assign out_edge   = out_edge_q;
    assign edge_count = edge_count_q;
endmodule

// File: tb/tb_sobel_mag_scheduler.sv
// Directed testbench for sobel_mag_scheduler; a second instance with CNT_W=4 checks counter saturation.
module tb_sobel_mag_scheduler;
    localparam int unsigned NL = 4;
    localparam int unsigned GW = 11;

    logic            clk;
    logic            rst;
    logic [NL-1:0]   lane_valid;
    logic [NL*GW-1:0] lane_gx;
    logic [NL*GW-1:0] lane_gy;
    logic [NL-1:0]   lane_ready;
    logic [7:0]      threshold;
    logic            clear_count;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_pixel;
    logic [1:0]      out_lane;
    logic            out_edge;
    logic [15:0]     edge_count;

    logic [NL-1:0]   lane_ready_s;
    logic            out_valid_s;
    logic [7:0]      out_pixel_s;
    logic [1:0]      out_lane_s;
    logic            out_edge_s;
    logic [3:0]      edge_count_s;

    int n_cmp = 0;
    int n_bad = 0;

    sobel_mag_scheduler #(.NUM_LANES(NL), .GW(GW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_gx(lane_gx), .lane_gy(lane_gy),
        .lane_ready(lane_ready), .threshold(threshold), .clear_count(clear_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_lane(out_lane), .out_edge(out_edge), .edge_count(edge_count)
    );

    sobel_mag_scheduler #(.NUM_LANES(NL), .GW(GW), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_gx(lane_gx), .lane_gy(lane_gy),
        .lane_ready(lane_ready_s), .threshold(threshold), .clear_count(clear_count),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_pixel(out_pixel_s),
        .out_lane(out_lane_s), .out_edge(out_edge_s), .edge_count(edge_count_s)
    );

    always #5 clk = ~clk;

    task automatic set_lane(input int i, input int gx, input int gy);
        lane_gx[i*GW +: GW] = GW'(gx);
        lane_gy[i*GW +: GW] = GW'(gy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; lane_valid = '0; clear_count = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; lane_valid = 4'b1111;
        @(negedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0d want 0", out_valid); end
        n_cmp++; if (out_pixel !== 8'd0) begin n_bad++; $display("FAIL reset_out_pixel got %0d want 0", out_pixel); end
        n_cmp++; if (out_lane !== 2'd0) begin n_bad++; $display("FAIL reset_out_lane got %0d want 0", out_lane); end
        n_cmp++; if (out_edge !== 1'b0) begin n_bad++; $display("FAIL reset_out_edge got %0d want 0", out_edge); end
        n_cmp++; if (edge_count !== 16'd0) begin n_bad++; $display("FAIL reset_edge_count got %0d want 0", edge_count); end
        n_cmp++; if (lane_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_lane_ready got %b want 0000", lane_ready); end
        rst = 1'b0; lane_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        threshold = 8'd100;
        @(negedge clk);
        set_lane(0, -3, 4); lane_valid = 4'b0001;
        #1;
        n_cmp++; if (lane_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant got %b want 0001", lane_ready); end
        @(negedge clk);
        lane_valid = '0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got %0d want 0", out_valid); end
        @(negedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %0d want 1", out_valid); end
        n_cmp++; if (out_pixel !== 8'd7) begin n_bad++; $display("FAIL single_pixel got %0d want 7", out_pixel); end
        n_cmp++; if (out_lane !== 2'd0) begin n_bad++; $display("FAIL single_lane got %0d want 0", out_lane); end
        n_cmp++; if (out_edge !== 1'b0) begin n_bad++; $display("FAIL single_edge got %0d want 0", out_edge); end
        @(negedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got %0d want 0", out_valid); end
    endtask

    task automatic test_saturation();
        int gx_t[4]  = '{-1024, 200, 127, 127};
        int gy_t[4]  = '{0, 100, 128, 127};
        int exp_t[4] = '{255, 255, 255, 254};
        threshold = 8'd255;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_lane(1, gx_t[i], gy_t[i]); lane_valid = 4'b0010;
            @(negedge clk);
            lane_valid = '0;
            @(negedge clk); #1;
            n_cmp++; if (out_pixel !== 8'(exp_t[i]) || out_valid !== 1'b1)
                begin n_bad++; $display("FAIL sat_pixel[%0d] got %0d (valid %0d) want %0d", i, out_pixel, out_valid, exp_t[i]); end
            n_cmp++; if (out_lane !== 2'd1) begin n_bad++; $display("FAIL sat_lane[%0d] got %0d want 1", i, out_lane); end
            n_cmp++; if (out_edge !== (exp_t[i] == 255)) begin n_bad++; $display("FAIL sat_edge[%0d] got %0d want %0d", i, out_edge, exp_t[i] == 255); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        threshold = 8'd0;
        for (int i = 0; i < 4; i++) set_lane(i, 10 * (i + 1), -5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) lane_valid = 4'b1111;
            if (k == 8) lane_valid = 4'b0000;
            #1;
            if (k < 8) begin
                n_cmp++; if (lane_ready !== 4'(1 << (k % 4)))
                    begin n_bad++; $display("FAIL rr_grant[%0d] got %b want %b", k, lane_ready, 4'(1 << (k % 4))); end
            end
            if (k >= 2) begin
                n_cmp++; if (out_valid !== 1'b1 || out_lane !== 2'((k - 2) % 4))
                    begin n_bad++; $display("FAIL rr_lane[%0d] got %0d (valid %0d) want %0d", k, out_lane, out_valid, (k - 2) % 4); end
                n_cmp++; if (out_pixel !== 8'(10 * ((k - 2) % 4 + 1) + 5))
                    begin n_bad++; $display("FAIL rr_pixel[%0d] got %0d want %0d", k, out_pixel, 10 * ((k - 2) % 4 + 1) + 5); end
            end
        end
        @(negedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drain got %0d want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got  = 0;
        do_reset();
        threshold = 8'd0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (sent < 5) begin set_lane(2, 11 + sent, 0); lane_valid = 4'b0100; end
            else lane_valid = 4'b0000;
            out_ready = !(c >= 4 && c <= 6);
            #1;
            if (c >= 4 && c <= 6) begin
                n_cmp++; if (lane_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready[%0d] got %b want 0000", c, lane_ready); end
            end
            if (lane_valid[2] && lane_ready[2]) sent++;
            if (out_valid) begin
                n_cmp++; if (out_pixel !== 8'(11 + got)) begin n_bad++; $display("FAIL bp_pixel[%0d] got %0d want %0d", c, out_pixel, 11 + got); end
                n_cmp++; if (out_lane !== 2'd2) begin n_bad++; $display("FAIL bp_lane[%0d] got %0d want 2", c, out_lane); end
                if (out_ready) got++;
            end
        end
        n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL bp_count got %0d want 5", got); end
        out_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup got %0d want 0", out_valid); end
    endtask

    task automatic test_counter();
        int vals[3] = '{49, 50, -1024};
        do_reset();
        threshold = 8'd50;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_lane(0, vals[i], 0); lane_valid = 4'b0001;
        end
        @(negedge clk);
        lane_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++; if (edge_count !== 16'd2) begin n_bad++; $display("FAIL cnt_thresh got %0d want 2", edge_count); end
        n_cmp++; if (edge_count_s !== 4'd2) begin n_bad++; $display("FAIL cnt_thresh_small got %0d want 2", edge_count_s); end
        // clear coincides with an edge result being accepted
        @(negedge clk);
        set_lane(0, 100, 0); lane_valid = 4'b0001;
        @(negedge clk);
        lane_valid = '0;
        @(negedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_edge !== 1'b1)
            begin n_bad++; $display("FAIL cnt_clr_setup got valid %0d edge %0d want 1 1", out_valid, out_edge); end
        clear_count = 1'b1;
        @(negedge clk); #1;
        clear_count = 1'b0;
        n_cmp++; if (edge_count !== 16'd0) begin n_bad++; $display("FAIL cnt_clear got %0d want 0", edge_count); end
        threshold = 8'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_lane(0, 1, 0); lane_valid = 4'b0001;
        end
        @(negedge clk);
        lane_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++; if (edge_count !== 16'd20) begin n_bad++; $display("FAIL cnt_twenty got %0d want 20", edge_count); end
        n_cmp++; if (edge_count_s !== 4'd15) begin n_bad++; $display("FAIL cnt_saturate got %0d want 15", edge_count_s); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        threshold = 8'd0;
        for (int i = 0; i < 4; i++) set_lane(i, 1, 1);
        @(negedge clk);
        lane_valid = 4'b1111;
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (edge_count === 16'd0 || out_valid !== 1'b1)
            begin n_bad++; $display("FAIL mid_setup got count %0d valid %0d want nonzero 1", edge_count, out_valid); end
        rst = 1'b1; #1;
        n_cmp++; if (lane_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready_in_rst got %b want 0000", lane_ready); end
        @(negedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid got %0d want 0", out_valid); end
        n_cmp++; if (edge_count !== 16'd0) begin n_bad++; $display("FAIL mid_edge_count got %0d want 0", edge_count); end
        rst = 1'b0; out_ready = 1'b1; #1;
        n_cmp++; if (lane_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant got %b want 0001", lane_ready); end
        @(negedge clk);
        lane_valid = '0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_flushed got %0d want 0", out_valid); end
        @(negedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_pixel !== 8'd2)
            begin n_bad++; $display("FAIL mid_first_out got valid %0d lane %0d pix %0d want 1 0 2", out_valid, out_lane, out_pixel); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; lane_valid = '0; lane_gx = '0; lane_gy = '0;
        threshold = '0; clear_count = 1'b0; out_ready = 1'b1;
        test_reset();
        test_single();
        test_saturation();
        test_round_robin();
        test_backpressure();
        test_counter();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
